fft_stage_ctrl: RTL and testbench
=================================

Name: fft_stage_ctrl

Overview:
Sequencer for the in-place radix-2 DIT FFT core (N = 2^LOG2N, default 256).
- Runs after the bit-reversed load address generator has filled the data RAM.
- Steps through LOG2N butterfly stages and issues, per butterfly, a dual read address pair, a twiddle ROM address and a latency-matched write-back address pair.
- Drains the butterfly pipeline between stages so no stage reads data before the previous stage has written it.

Parameters:
LOG2N, 8, log2 of FFT length; N = 2^LOG2N, N/2 butterflies per stage.
BF_LAT, 3, butterfly datapath latency in cycles from read-address cycle to write-back cycle; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  level-sampled in IDLE only; ignored in all other states.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse when the final stage has fully written back.
stage  out  ceil(log2(LOG2N))  current stage index (3 bits at default).
rd_en  out  1  read strobe to the data RAM, both ports.
rd_addr_a  out  LOG2N  butterfly top-input address.
rd_addr_b  out  LOG2N  butterfly bottom-input address.
tw_addr  out  LOG2N-1  twiddle ROM address, aligned with rd_en.
wr_en  out  1  write strobe to the data RAM, both ports.
wr_addr_a  out  LOG2N  write-back address for the top output.
wr_addr_b  out  LOG2N  write-back address for the bottom output.

Behaviour:
- All outputs are registered. Async reset (rst=0) forces IDLE, stage=0, k=0, every output 0, and clears the write delay line. Reset mid-operation aborts with no further writes.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN, with stage=0 and k=0.
  - RUN: one butterfly per cycle, rd_en=1, k = 0..N/2-1. After k = N/2-1 -> DRAIN, drain counter = 0.
  - DRAIN: rd_en=0 for exactly BF_LAT cycles. Then go to RUN with stage+1 and k=0, or go to DONE if stage = LOG2N-1.
  - DONE: done=1 for one cycle, busy=0, then IDLE. stage holds LOG2N-1 until the next start.
- Address arithmetic for stage s, butterfly k, with span = 2^s:
  - pos = k mod span; grp = k >> s.
  - rd_addr_a = grp*2*span + pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (LOG2N-1-s).
  - Implemented with shifts and masks only, no multipliers. All values fit their port widths, with no wrap-around.
- rd_addr_*/tw_addr hold their last value while rd_en=0. Consumers qualify them with rd_en only.
- Write-back: wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed exactly BF_LAT cycles. The delay line is a shift register of depth BF_LAT.
  - The last write of a stage occurs in the last DRAIN cycle.
  - The first read of the next stage occurs in the following cycle, so there is no read-before-write hazard.
- Timing, with start sampled at edge 0:
  - First rd_en cycle = cycle 1.
  - Each stage takes N/2+BF_LAT cycles.
  - done is high in cycle LOG2N*(N/2+BF_LAT)+1, which is 1049 at the defaults.
  - busy is high in cycles 1..1048.
- start held high continuously: a new transform starts in the cycle after DONE returns to IDLE, so one idle cycle separates runs.
- start asserted during busy or DONE is ignored and is not queued.
- Count of rd_en=1 cycles per transform = count of wr_en=1 cycles per transform = LOG2N*N/2 (1024).

Decomposition:
- Shared package fft_pkg holds:
  - the constants LOG2N, N and BF_LAT defaults;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - a function computing the (a, b, tw) addresses from (stage, k), reused by the bench's reference model.
- One sub-module: fft_addr_delay, a parameterised BF_LAT-deep shift register carrying {valid, addr_a, addr_b} with async active-low reset.

Test Plan:
1. Reset during RUN (stage 2, k=40), then rst=0 for 1 cycle -> all outputs 0 next cycle, no wr_en afterwards; a subsequent start runs a full, correct transform.
2. Single start pulse -> stage 0 reads in order: k=0 gives a=0, b=1, tw=0; k=1 gives a=2, b=3. Stage 1 k=1 gives a=1, b=3, tw=64. Stage 2 k=5 gives a=9, b=13, tw=32. Stage 7 k=5 gives a=5, b=133, tw=5.
3. Full run at defaults -> done high only in cycle 1049; exactly 1024 rd_en and 1024 wr_en cycles; each wr pair matches the rd pair from 3 cycles earlier.
4. Stage boundary -> last wr_en of stage s is in the cycle immediately before the first rd_en of stage s+1. In every cycle, no read address equals an outstanding unwritten address.
5. start pulsed at cycle 500 and during DONE -> ignored; a single done, timing unchanged. start held high -> second run's first rd_en is 2 cycles after done.
6. Reconfigure with LOG2N=4, BF_LAT=1 -> 4 stages of 9 cycles, done in cycle 37, and all addresses match the fft_pkg model.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and butterfly address arithmetic for the
// in-place radix-2 DIT FFT stage sequencer.
package fft_pkg;

  localparam int unsigned DefLog2n = 8;
  localparam int unsigned DefN     = 1 << DefLog2n;
  localparam int unsigned DefBfLat = 3;
  localparam int unsigned AddrMaxW = 16;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} fft_state_e;

  typedef struct packed {
    logic [AddrMaxW-1:0] a;
    logic [AddrMaxW-1:0] b;
    logic [AddrMaxW-1:0] tw;
  } fft_addr_t;

  // Butterfly k of a stage pairs a and a + 2^stage; bit 'stage' of a is always
  // clear, so the add reduces to an OR.
  function automatic fft_addr_t fft_addrs(input int unsigned log2n, input int unsigned stage,
                                          input int unsigned k);
    int unsigned span_mask;
    int unsigned pos;
    int unsigned grp;
    fft_addr_t   r;
    span_mask = (32'd1 << stage) - 32'd1;
    pos       = k & span_mask;
    grp       = k >> stage;
    r.a       = AddrMaxW'((grp << (stage + 32'd1)) | pos);
    r.b       = r.a | AddrMaxW'(32'd1 << stage);
    r.tw      = AddrMaxW'(pos << (log2n - 32'd1 - stage));
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-latency shift register carrying a read strobe and address pair to the
// write-back side of the butterfly pipeline.
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int unsigned Depth = 3,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [AddrW-1:0] addr_a_i,
  input  logic [AddrW-1:0] addr_b_i,
  output logic             valid_o,
  output logic [AddrW-1:0] addr_a_o,
  output logic [AddrW-1:0] addr_b_o
);

  localparam int unsigned W = 2 * AddrW + 1;

  logic [Depth-1:0][W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= {valid_i, addr_a_i, addr_b_i};
      for (int unsigned i = 1; i < Depth; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign {valid_o, addr_a_o, addr_b_o} = sr_q[Depth-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for the in-place radix-2 DIT FFT: issues butterfly read,
// twiddle and latency-matched write-back addresses, draining between stages.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = DefLog2n,
  parameter int unsigned BF_LAT = DefBfLat,
  localparam int unsigned StageW = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [StageW-1:0] stage,
  output logic              rd_en,
  output logic [LOG2N-1:0]  rd_addr_a,
  output logic [LOG2N-1:0]  rd_addr_b,
  output logic [LOG2N-2:0]  tw_addr,
  output logic              wr_en,
  output logic [LOG2N-1:0]  wr_addr_a,
  output logic [LOG2N-1:0]  wr_addr_b
);

  localparam int unsigned KW = LOG2N - 1;
  localparam logic [KW-1:0] KLast = '1;
  localparam logic [StageW-1:0] StageLast = StageW'(LOG2N - 1);
  localparam logic [3:0] DrainLast = 4'(BF_LAT - 1);

  fft_state_e        state_q, state_d;
  logic [StageW-1:0] stage_q, stage_d;
  logic [KW-1:0]     k_q, k_d;
  logic [3:0]        drain_q, drain_d;
  fft_addr_t         addr;
  logic              unused_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        k_d = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DrainLast) begin
          if (stage_q == StageLast) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr = fft_addrs(LOG2N, 32'(stage_q), 32'(k_q));
  end

  assign unused_addr = ^{addr.a[AddrMaxW-1:LOG2N], addr.b[AddrMaxW-1:LOG2N],
                         addr.tw[AddrMaxW-1:LOG2N-1]};

  // Outputs are a registered decode of the FSM, one cycle behind its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      rd_en <= (state_q == StRun);
      busy  <= (state_q == StRun) || (state_q == StDrain);
      done  <= (state_q == StDone);
      stage <= stage_q;
      if (state_q == StRun) begin
        rd_addr_a <= addr.a[LOG2N-1:0];
        rd_addr_b <= addr.b[LOG2N-1:0];
        tw_addr   <= addr.tw[LOG2N-2:0];
      end
    end
  end

  fft_addr_delay #(
    .Depth(BF_LAT),
    .AddrW(LOG2N)
  ) u_wr_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_en),
    .addr_a_i(rd_addr_a),
    .addr_b_i(rd_addr_b),
    .valid_o (wr_en),
    .addr_a_o(wr_addr_a),
    .addr_b_o(wr_addr_b)
  );

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at default size and at LOG2N=4, BF_LAT=1.
module tb_fft_stage_ctrl;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_big = 1'b0;
  logic start_sm = 1'b0;

  logic       b_busy, b_done, b_rd_en, b_wr_en;
  logic [2:0] b_stage;
  logic [7:0] b_ra, b_rb, b_wa, b_wb;
  logic [6:0] b_tw;

  logic       s_busy, s_done, s_rd_en, s_wr_en;
  logic [1:0] s_stage;
  logic [3:0] s_ra, s_rb, s_wa, s_wb;
  logic [2:0] s_tw;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd_en, wr_en, busy, done;
    logic [15:0] stage, a, b, tw, wa, wb;
  } obs_t;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2N(8), .BF_LAT(3)) u_big (
    .clk(clk), .rst(rst), .start(start_big), .busy(b_busy), .done(b_done), .stage(b_stage),
    .rd_en(b_rd_en), .rd_addr_a(b_ra), .rd_addr_b(b_rb), .tw_addr(b_tw),
    .wr_en(b_wr_en), .wr_addr_a(b_wa), .wr_addr_b(b_wb)
  );

  fft_stage_ctrl #(.LOG2N(4), .BF_LAT(1)) u_sm (
    .clk(clk), .rst(rst), .start(start_sm), .busy(s_busy), .done(s_done), .stage(s_stage),
    .rd_en(s_rd_en), .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_addr(s_tw),
    .wr_en(s_wr_en), .wr_addr_a(s_wa), .wr_addr_b(s_wb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(input bit sm);
    obs_t o;
    if (sm) begin
      o.rd_en = s_rd_en; o.wr_en = s_wr_en; o.busy = s_busy; o.done = s_done;
      o.stage = 16'(s_stage); o.a = 16'(s_ra); o.b = 16'(s_rb); o.tw = 16'(s_tw);
      o.wa = 16'(s_wa); o.wb = 16'(s_wb);
    end else begin
      o.rd_en = b_rd_en; o.wr_en = b_wr_en; o.busy = b_busy; o.done = b_done;
      o.stage = 16'(b_stage); o.a = 16'(b_ra); o.b = 16'(b_rb); o.tw = 16'(b_tw);
      o.wa = 16'(b_wa); o.wb = 16'(b_wb);
    end
    return o;
  endfunction

  task automatic set_start(input bit sm, input bit v);
    if (sm) start_sm = v;
    else start_big = v;
  endtask

  // Reference schedule: cycle c (1-based after the start edge) reads stage s, butterfly k.
  function automatic void exp_rd(input int c, input int l2, input int bl, output bit en,
                                 output int s, output int k);
    int half = 1 << (l2 - 1);
    int per = half + bl;
    en = 1'b0; s = 0; k = 0;
    if (c >= 1 && c <= l2 * per) begin
      s = (c - 1) / per;
      k = (c - 1) % per;
      en = (k < half);
    end
  endfunction

  task automatic run_check(input bit sm, input int x1, input int x2, input bit hold);
    int l2 = sm ? 4 : 8;
    int bl = sm ? 1 : 3;
    int half = 1 << (l2 - 1);
    int last = l2 * (half + bl);
    int lim = hold ? last + 3 : last + 6;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = -1, hazards = 0, last_wr = -1;
    int dc[5] = '{1, 2, 133, 268, 923};
    int da[5] = '{0, 2, 1, 9, 5};
    int db[5] = '{1, 3, 3, 13, 133};
    int dt[5] = '{0, 0, 64, 32, 5};
    bit prev_rd = 1'b0;
    bit hen[16];
    logic [15:0] ha[16], hb[16];
    obs_t o;
    fft_addr_t e;
    bit en;
    int s, k, idx;
    for (int i = 0; i < 16; i++) hen[i] = 1'b0;
    set_start(sm, 1'b1);
    @(posedge clk); #1;
    set_start(sm, hold);
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      o = get_obs(sm);
      if (c <= last + 1) begin
        exp_rd(c, l2, bl, en, s, k);
        check_eq("rd_en", o.rd_en, en);
        check_eq("busy", o.busy, c <= last);
        check_eq("done", o.done, c == last + 1);
        check_eq("stage", o.stage, (c <= last) ? s : l2 - 1);
        if (en) begin
          e = fft_addrs(l2, s, k);
          check_eq("rd_addr_a", o.a, e.a);
          check_eq("rd_addr_b", o.b, e.b);
          check_eq("tw_addr", o.tw, e.tw);
        end
        exp_rd(c - bl, l2, bl, en, s, k);
        check_eq("wr_en", o.wr_en, en);
        if (en) begin
          e = fft_addrs(l2, s, k);
          check_eq("wr_addr_a", o.wa, e.a);
          check_eq("wr_addr_b", o.wb, e.b);
        end
        if (!sm) begin
          for (int i = 0; i < 5; i++) begin
            if (c == dc[i]) begin
              check_eq("dir_a", o.a, da[i]);
              check_eq("dir_b", o.b, db[i]);
              check_eq("dir_tw", o.tw, dt[i]);
            end
          end
        end
        rd_cnt += int'(o.rd_en);
        wr_cnt += int'(o.wr_en);
        if (o.done) begin
          done_cnt++;
          done_cyc = c;
        end
        if (o.rd_en) begin
          for (int d = 1; d <= bl; d++) begin
            idx = (c - d) & 15;
            if (hen[idx] && (o.a == ha[idx] || o.a == hb[idx] || o.b == ha[idx] ||
                             o.b == hb[idx]))
              hazards++;
          end
        end
        hen[c & 15] = o.rd_en; ha[c & 15] = o.a; hb[c & 15] = o.b;
        if (o.rd_en && !prev_rd && last_wr >= 0) check_eq("stage_gap", c - last_wr, 1);
        if (o.wr_en) last_wr = c;
        prev_rd = o.rd_en;
      end else if (!hold) begin
        check_eq("idle_rd_en", o.rd_en, 0);
        check_eq("idle_wr_en", o.wr_en, 0);
        check_eq("idle_busy", o.busy, 0);
        check_eq("idle_done", o.done, 0);
        check_eq("idle_stage", o.stage, l2 - 1);
      end else if (c == last + 2) begin
        check_eq("hold_gap_rd", o.rd_en, 0);
        check_eq("hold_gap_busy", o.busy, 0);
      end else begin
        check_eq("hold_restart_rd", o.rd_en, 1);
        check_eq("hold_restart_a", o.a, 0);
        check_eq("hold_restart_b", o.b, 1);
      end
      set_start(sm, hold || c == x1 || c == x2);
    end
    check_eq("rd_count", rd_cnt, sm ? 32 : 1024);
    check_eq("wr_count", wr_cnt, sm ? 32 : 1024);
    check_eq("done_count", done_cnt, 1);
    check_eq("done_cycle", done_cyc, sm ? 37 : 1049);
    check_eq("hazards", hazards, 0);
    set_start(sm, 1'b0);
  endtask

  task automatic abort_check();
    obs_t o;
    int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0;
    start_big = 1'b1;
    @(posedge clk); #1;
    start_big = 1'b0;
    repeat (302) @(posedge clk);
    #1;
    check_eq("pre_abort_stage", b_stage, 2);
    rst = 1'b0;
    @(posedge clk); #1;
    o = get_obs(1'b0);
    check_eq("abort_rd_en", o.rd_en, 0);
    check_eq("abort_wr_en", o.wr_en, 0);
    check_eq("abort_busy", o.busy, 0);
    check_eq("abort_done", o.done, 0);
    check_eq("abort_stage", o.stage, 0);
    check_eq("abort_addrs", {o.a, o.b}, 0);
    check_eq("abort_tw", o.tw, 0);
    check_eq("abort_waddrs", {o.wa, o.wb}, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rd_cnt += int'(b_rd_en);
      wr_cnt += int'(b_wr_en);
      busy_cnt += int'(b_busy);
    end
    check_eq("post_abort_rd", rd_cnt, 0);
    check_eq("post_abort_wr", wr_cnt, 0);
    check_eq("post_abort_busy", busy_cnt, 0);
  endtask

  initial begin
    obs_t o;
    repeat (2) @(posedge clk);
    #1;
    o = get_obs(1'b0);
    check_eq("reset_busy", o.busy, 0);
    check_eq("reset_done", o.done, 0);
    check_eq("reset_rd_en", o.rd_en, 0);
    check_eq("reset_wr_en", o.wr_en, 0);
    check_eq("reset_stage", o.stage, 0);
    check_eq("reset_addrs", {o.a, o.b, o.tw}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    abort_check();
    // Stray starts while busy and while in DONE must be ignored.
    run_check(1'b0, 500, 1048, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    run_check(1'b0, -1, -1, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_check(1'b1, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
